// File: rtl/hwpf_fifo.sv
// rtl/hwpf_fifo.sv - prefetch address FIFO with duplicate filtering and multi-port insertion

package drac_pkg;
    typedef logic [39:0] addr_t;
endpackage

module hwpf_fifo #(
    parameter int QUEUE_DEPTH = 3,
    parameter int INSERTS     = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            lock_i,
    input  logic            take_req_i   [INSERTS-1:0],
    input  drac_pkg::addr_t cpu_req_i    [INSERTS-1:0],
    output drac_pkg::addr_t data_cpu_o   [QUEUE_DEPTH-1:0],
    output logic            data_valid_o [QUEUE_DEPTH-1:0]
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    drac_pkg::addr_t  data_q  [QUEUE_DEPTH-1:0];
    drac_pkg::addr_t  data_d  [QUEUE_DEPTH-1:0];
    logic             valid_q [QUEUE_DEPTH-1:0];
    logic             valid_d [QUEUE_DEPTH-1:0];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             keep    [INSERTS-1:0];
    logic [PTR_W-1:0] slot_idx;
    int               cnt;
    int               slot;
    int               sum;

    // Filter candidates against stored and earlier same-cycle addresses, then
    // pack survivors into consecutive slots starting at the write pointer.
    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        cnt      = 0;
        slot     = 0;
        sum      = 0;
        slot_idx = '0;
        for (int i = 0; i < INSERTS; i++) begin
            keep[i] = 1'b0;
        end
        for (int i = 0; i < INSERTS; i++) begin
            keep[i] = take_req_i[i] && !lock_i && !flush_i;
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                if (valid_q[e] && (data_q[e] == cpu_req_i[i])) begin
                    keep[i] = 1'b0;
                end
            end
            for (int j = 0; j < i; j++) begin
                if (keep[j] && (cpu_req_i[j] == cpu_req_i[i])) begin
                    keep[i] = 1'b0;
                end
            end
            if (keep[i]) begin
                // ptr + cnt never reaches 2*QUEUE_DEPTH, so one subtraction wraps it
                slot = int'(ptr_q) + cnt;
                if (slot >= QUEUE_DEPTH) begin
                    slot = slot - QUEUE_DEPTH;
                end
                slot_idx          = PTR_W'(slot);
                data_d[slot_idx]  = cpu_req_i[i];
                valid_d[slot_idx] = 1'b1;
                cnt               = cnt + 1;
            end
        end
        sum = int'(ptr_q) + cnt;
        if (sum >= QUEUE_DEPTH) begin
            sum = sum - QUEUE_DEPTH;
        end
        ptr_d = PTR_W'(sum);
        // Flush drops validity and rewinds the pointer; stale addresses are kept
        if (flush_i) begin
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                valid_d[e] = 1'b0;
            end
            ptr_d = '0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                data_q[e]  <= '0;
                valid_q[e] <= 1'b0;
            end
            ptr_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data_cpu_o   = data_q;
    assign data_valid_o = valid_q;

endmodule

// File: tb/tb_hwpf_fifo.sv
// tb/tb_hwpf_fifo.sv - vector table and scoreboard bench for hwpf_fifo

module tb_hwpf_fifo;

    localparam logic [39:0] C = 40'hCAFE0000;
    localparam logic [39:0] Z = 40'h0;

    typedef struct {
        logic            flush;
        logic            lock;
        logic            t0;
        logic            t1;
        logic [39:0]     a0;
        logic [39:0]     a1;
        logic [2:0]      ev;
        logic [2:0][39:0] ed;
    } vec_t;

    typedef struct {
        logic [2:0]       ev;
        logic [2:0][39:0] ed;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        lock_i = 1'b0;
    logic        take_req [1:0];
    logic [39:0] cpu_req  [1:0];
    logic [39:0] data_cpu [2:0];
    logic        data_valid [2:0];

    int tests = 0;
    int failed = 0;
    exp_t sb [$];
    exp_t last_exp;
    vec_t vecs [20];

    hwpf_fifo #(.QUEUE_DEPTH(3), .INSERTS(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .lock_i      (lock_i),
        .take_req_i  (take_req),
        .cpu_req_i   (cpu_req),
        .data_cpu_o  (data_cpu),
        .data_valid_o(data_valid)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic f, input logic l, input logic t0, input logic t1,
                                input logic [39:0] a0, input logic [39:0] a1, input logic [2:0] ev,
                                input logic [39:0] d0, input logic [39:0] d1, input logic [39:0] d2);
        vec_t v;
        v.flush = f; v.lock = l; v.t0 = t0; v.t1 = t1;
        v.a0 = a0; v.a1 = a1; v.ev = ev;
        v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
        return v;
    endfunction

    task automatic check_state(input string name, input logic [2:0] ev, input logic [2:0][39:0] ed);
        logic [2:0]       gv;
        logic [2:0][39:0] gd;
        for (int e = 0; e < 3; e++) begin
            gv[e] = data_valid[e];
            gd[e] = data_cpu[e];
        end
        tests++;
        if (gv !== ev) begin
            failed++;
            $display("FAIL %s valid: got %b expected %b", name, gv, ev);
        end
        tests++;
        if (gd !== ed) begin
            failed++;
            $display("FAIL %s data: got %h expected %h", name, gd, ed);
        end
    endtask

    task automatic drive(input logic f, input logic l, input logic t0, input logic t1,
                         input logic [39:0] a0, input logic [39:0] a1);
        flush_i = f; lock_i = l;
        take_req[0] = t0; take_req[1] = t1;
        cpu_req[0] = a0; cpu_req[1] = a1;
    endtask

    initial begin
        exp_t x;
        // bit e of ev is entry e; data listed entry0, entry1, entry2
        vecs[0]  = mk(0,0,0,0, Z,     Z,     3'b000, Z,     Z,     Z);
        vecs[1]  = mk(0,0,0,0, Z,     Z,     3'b000, Z,     Z,     Z);
        vecs[2]  = mk(0,1,1,0, C,     Z,     3'b000, Z,     Z,     Z);
        vecs[3]  = mk(0,0,1,0, C,     Z,     3'b001, C,     Z,     Z);
        vecs[4]  = mk(1,0,0,0, Z,     Z,     3'b000, C,     Z,     Z);
        vecs[5]  = mk(1,0,1,0, C,     Z,     3'b000, C,     Z,     Z);
        vecs[6]  = mk(0,0,1,1, C,     C+1,   3'b011, C,     C+1,   Z);
        vecs[7]  = mk(0,0,1,0, C+2,   Z,     3'b111, C,     C+1,   C+2);
        vecs[8]  = mk(0,0,1,1, C,     C+1,   3'b111, C,     C+1,   C+2);
        vecs[9]  = mk(0,0,1,0, C+3,   Z,     3'b111, C+3,   C+1,   C+2);
        vecs[10] = mk(0,0,1,1, C+4,   C+4,   3'b111, C+3,   C+4,   C+2);
        vecs[11] = mk(0,0,0,1, Z,     C+5,   3'b111, C+3,   C+4,   C+5);
        vecs[12] = mk(0,0,1,1, C+4,   C+7,   3'b111, C+7,   C+4,   C+5);
        vecs[13] = mk(1,1,1,1, C+8,   C+9,   3'b000, C+7,   C+4,   C+5);
        vecs[14] = mk(0,0,1,0, C+7,   Z,     3'b001, C+7,   C+4,   C+5);
        vecs[15] = mk(0,1,1,1, C+9,   C+10,  3'b001, C+7,   C+4,   C+5);
        vecs[16] = mk(0,0,1,1, C+10,  C+11,  3'b111, C+7,   C+10,  C+11);
        vecs[17] = mk(0,0,1,0, C+12,  Z,     3'b111, C+12,  C+10,  C+11);
        vecs[18] = mk(0,0,1,0, C+13,  Z,     3'b111, C+12,  C+13,  C+11);
        vecs[19] = mk(0,0,1,1, C+14,  C+15,  3'b111, C+15,  C+13,  C+14);

        drive(0, 0, 0, 0, Z, Z);
        #2;
        last_exp.ev = 3'b000;
        for (int e = 0; e < 3; e++) last_exp.ed[e] = Z;
        check_state("reset_hold", last_exp.ev, last_exp.ed);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            drive(vecs[i].flush, vecs[i].lock, vecs[i].t0, vecs[i].t1, vecs[i].a0, vecs[i].a1);
            x.ev = vecs[i].ev;
            x.ed = vecs[i].ed;
            sb.push_back(x);
            #1;
            check_state($sformatf("pre_edge_v%0d", i), last_exp.ev, last_exp.ed);
            @(posedge clk_i);
            #1;
            if (sb.size() == 0) begin
                tests++; failed++;
                $display("FAIL scoreboard_empty_v%0d: got 0 entries expected 1", i);
            end else begin
                last_exp = sb.pop_front();
                check_state($sformatf("post_edge_v%0d", i), last_exp.ev, last_exp.ed);
            end
        end

        // Asynchronous reset asserted between clock edges clears state at once
        @(negedge clk_i);
        drive(0, 0, 0, 0, Z, Z);
        #2;
        rst_ni = 1'b0;
        #1;
        last_exp.ev = 3'b000;
        for (int e = 0; e < 3; e++) last_exp.ed[e] = Z;
        check_state("async_reset", last_exp.ev, last_exp.ed);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // First insertion after reset lands in entry 0
        @(negedge clk_i);
        drive(0, 0, 1, 0, C+16, Z);
        x.ev = 3'b001;
        x.ed[0] = C+16; x.ed[1] = Z; x.ed[2] = Z;
        sb.push_back(x);
        #1;
        check_state("post_reset_pre_edge", last_exp.ev, last_exp.ed);
        @(posedge clk_i);
        #1;
        last_exp = sb.pop_front();
        check_state("post_reset_first_insert", last_exp.ev, last_exp.ed);

        // Two back-to-back inserts then an idle cycle leaves state unchanged
        @(negedge clk_i);
        drive(0, 0, 1, 1, C+17, C+18);
        @(posedge clk_i);
        #1;
        check_state("fill_after_reset", 3'b111, {C+18, C+17, C+16});
        @(negedge clk_i);
        drive(0, 0, 0, 0, C+19, C+20);
        @(posedge clk_i);
        #1;
        check_state("idle_no_change", 3'b111, {C+18, C+17, C+16});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
